// File: rtl/xor_share_arb_pkg.sv
// Shared types and helpers for the xor_share_arb round-robin XOR sequencer.
package xor_share_arb_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} xsa_state_t;

    localparam int STALL_CNT_W = 16;

    function automatic int xsa_id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/xsa_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping to 0.
module xsa_rr_pick
    import xor_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = xsa_id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    // Two passes: indices at/above ptr first, then the wrapped-around ones below ptr.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (j >= 32'(ptr))) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (j < 32'(ptr))) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/xor_share_arb.sv
// Round-robin arbiter sharing one registered XOR stage among NREQ requesters.
// Optional stall counter output enabled by defining XOR_SHARE_ARB_STALL_CNT_EN.
module xor_share_arb
    import xor_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = xsa_id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    input  logic              res_ready,
    output logic              busy
`ifdef XOR_SHARE_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    xsa_state_t      state, next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    sel_a, sel_b;
    logic            any;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  idx;

    xsa_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .any   (any),
        .grant (grant),
        .idx   (idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        next      = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    req_ready = grant;
                    next      = EXEC;
                end
            end
            EXEC:    next = DONE;
            DONE:    if (res_ready) next = IDLE;
            default: next = IDLE;
        endcase
        if (rst) req_ready = '0;
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_data <= '0;
            res_id   <= '0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (any) begin
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                        id_q <= idx;
                    end
                end
                EXEC: begin
                    res_data <= a_q ^ b_q;
                    res_id   <= id_q;
                end
                DONE: begin
                    if (res_ready)
                        ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef XOR_SHARE_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == DONE) && !res_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: cycle table on NREQ=4 plus hand sequences (reset, NREQ=3 wrap).
module tb_xor_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;

    logic [2:0]  v3;
    logic [23:0] a3, b3;
    logic [2:0]  ready3;
    logic        rv3;
    logic [7:0]  data3;
    logic [1:0]  id3;
    logic        rr3;
    logic        busy3;

`ifdef XOR_SHARE_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_share_arb #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef XOR_SHARE_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    xor_share_arb #(.NREQ(3), .W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v3),
        .req_a     (a3),
        .req_b     (b3),
        .req_ready (ready3),
        .res_valid (rv3),
        .res_data  (data3),
        .res_id    (id3),
        .res_ready (rr3),
        .busy      (busy3)
`ifdef XOR_SHARE_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt3)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic [7:0]  e_data;
        logic [1:0]  e_id;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic rr, input logic [3:0] er, input logic erv, input logic [7:0] ed,
                       input logic [1:0] eid, input logic eb);
        vec_t t;
        t.rst = r; t.v = v; t.a = a; t.b = b; t.rr = rr;
        t.e_ready = er; t.e_rv = erv; t.e_data = ed; t.e_id = eid; t.e_busy = eb;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] SA = 32'h00A5_0000;
    localparam logic [31:0] SB = 32'h000F_0000;
    localparam logic [31:0] RA = 32'h0302_0100;
    localparam logic [31:0] RB = 32'hF0F0_F0F0;

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;

        // single request from requester 2
        add(0, 4'b0000, 0,  0,  1, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b0100, SA, SB, 1, 4'b0100, 0, 8'h00, 0, 0);
        add(0, 4'b0000, SA, SB, 1, 4'b0000, 0, 8'h00, 0, 1);
        add(0, 4'b0000, 0,  0,  1, 4'b0000, 1, 8'hAA, 2, 1);
        add(0, 4'b0000, 0,  0,  1, 4'b0000, 0, 8'hAA, 2, 0);
        // reset with all valid: ready forced low
        add(1, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'hAA, 2, 0);
        // round robin 0,1,2,3,0
        add(0, 4'b1111, RA, RB, 1, 4'b0001, 0, 8'h00, 0, 0);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'h00, 0, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 1, 8'hF0, 0, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0010, 0, 8'hF0, 0, 0);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'hF0, 0, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 1, 8'hF1, 1, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0100, 0, 8'hF1, 1, 0);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'hF1, 1, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 1, 8'hF2, 2, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b1000, 0, 8'hF2, 2, 0);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'hF2, 2, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 1, 8'hF3, 3, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0001, 0, 8'hF3, 3, 0);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 0, 8'hF3, 3, 1);
        add(0, 4'b1111, RA, RB, 1, 4'b0000, 1, 8'hF0, 0, 1);
        // backpressure: 5 stalled DONE cycles with everyone valid
        add(0, 4'b1111, RA, RB, 1, 4'b0010, 0, 8'hF0, 0, 0);
        add(0, 4'b1111, RA, RB, 0, 4'b0000, 0, 8'hF0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 4'b1111, RA, RB, 0, 4'b0000, 1, 8'hF1, 1, 1);
        // withdrawal: requester 1 valid during DONE, drops; requester 3 wins
        add(0, 4'b0010, RA, RB, 1, 4'b0000, 1, 8'hF1, 1, 1);
        add(0, 4'b1000, RA, RB, 1, 4'b1000, 0, 8'hF1, 1, 0);
        add(0, 4'b0000, RA, RB, 1, 4'b0000, 0, 8'hF1, 1, 1);
        add(0, 4'b0000, RA, RB, 1, 4'b0000, 1, 8'hF3, 3, 1);
        // serve requester 0 so ptr moves to 1
        add(0, 4'b0001, 32'h11, 32'h22, 1, 4'b0001, 0, 8'hF3, 3, 0);
        add(0, 4'b0000, 32'h11, 32'h22, 1, 4'b0000, 0, 8'hF3, 3, 1);
        add(0, 4'b0000, 0, 0, 1, 4'b0000, 1, 8'h33, 0, 1);
        add(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 8'h33, 0, 0);

        cyc();
        cyc();

        foreach (tbl[k]) begin
            rst = tbl[k].rst; req_valid = tbl[k].v; req_a = tbl[k].a; req_b = tbl[k].b;
            res_ready = tbl[k].rr;
            #1;
            chk($sformatf("row%0d_req_ready", k), 32'(req_ready), 32'(tbl[k].e_ready));
            chk($sformatf("row%0d_res_valid", k), 32'(res_valid), 32'(tbl[k].e_rv));
            chk($sformatf("row%0d_res_data", k), 32'(res_data), 32'(tbl[k].e_data));
            chk($sformatf("row%0d_res_id", k), 32'(res_id), 32'(tbl[k].e_id));
            chk($sformatf("row%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
            cyc();
        end

`ifdef XOR_SHARE_ARB_STALL_CNT_EN
        chk("stall_cnt_after_bp", 32'(stall_cnt), 32'd5);
`endif

        // reset mid-EXEC with requester 1 granted (ptr is 1 here)
        rst = 0; req_valid = 4'b0010; req_a = 32'h0000_5500; req_b = 32'h0000_0F00; res_ready = 1;
        #1;
        chk("rst_grant1", 32'(req_ready), 32'b0010);
        cyc();
        rst = 1; req_valid = '0;
        #1;
        chk("rst_exec_busy", 32'(busy), 32'd1);
        chk("rst_exec_ready", 32'(req_ready), 32'd0);
        cyc();
        #1;
        chk("rst_hold_valid", 32'(res_valid), 32'd0);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        chk("rst_hold_data", 32'(res_data), 32'd0);
        cyc();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rst_no_result%0d", i), 32'(res_valid), 32'd0);
            chk($sformatf("rst_idle_busy%0d", i), 32'(busy), 32'd0);
            cyc();
        end
`ifdef XOR_SHARE_ARB_STALL_CNT_EN
        chk("stall_cnt_reset", 32'(stall_cnt), 32'd0);
`endif
        req_valid = 4'b1111; req_a = RA; req_b = RB;
        #1;
        chk("rst_ptr0_grant", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("post_rst_valid", 32'(res_valid), 32'd1);
        chk("post_rst_data", 32'(res_data), 32'hF0);
        chk("post_rst_id", 32'(res_id), 32'd0);
        cyc();

        // NREQ=3 pointer wrap
        v3 = 3'b100; a3 = 24'h12_00_00; b3 = 24'h34_00_00;
        #1;
        chk("n3_grant2", 32'(ready3), 32'b100);
        cyc();
        v3 = '0;
        cyc();
        #1;
        chk("n3_valid2", 32'(rv3), 32'd1);
        chk("n3_data2", 32'(data3), 32'h26);
        chk("n3_id2", 32'(id3), 32'd2);
        cyc();
        v3 = 3'b101; a3 = 24'h12_00_05; b3 = 24'h34_00_0A;
        #1;
        chk("n3_wrap_grant0", 32'(ready3), 32'b001);
        cyc();
        v3 = '0;
        cyc();
        #1;
        chk("n3_data0", 32'(data3), 32'h0F);
        chk("n3_id0", 32'(id3), 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
